// File: rtl/scan_chain_loader.sv
// scan_chain_loader: serially loads a control-register scan chain and captures
// the previous chain contents shifted out of the dummy stage.
// Optional feature macro: READBACK_VERIFY_EN -- adds a second (VERIFY) pass of
// the latched word and a mismatch flag comparing the readback with that word.
module scan_chain_loader #(
    parameter int CHAIN_LEN = 34,
    parameter int CLK_DIV   = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [CHAIN_LEN-1:0] cfg_word,
    output logic                 busy,
    output logic                 done,
    output logic [CHAIN_LEN-1:0] rd_word,
    output logic                 sr_clk,
    output logic                 sr_data,
    input  logic                 sr_dout
`ifdef READBACK_VERIFY_EN
    ,
    output logic                 mismatch
`endif
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(CHAIN_LEN - 1);

`ifdef READBACK_VERIFY_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1, S_DONE = 2'd2, S_VERIFY = 2'd3} state_t;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1, S_DONE = 2'd2} state_t;
`endif

    state_t                 state_q, state_d;
    logic [DW-1:0]          div_cnt_q, div_cnt_d;
    logic [BW-1:0]          bit_cnt_q, bit_cnt_d;
    logic [CHAIN_LEN-1:0]   word_q, word_d;      // latched load word
    logic [CHAIN_LEN-1:0]   tx_q, tx_d;          // outgoing bits, MSB is next to send
    logic [CHAIN_LEN-1:0]   cap_q, cap_d;        // samples from sr_dout, first sample ends at MSB
    logic [CHAIN_LEN-1:0]   rd_word_q, rd_word_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   sr_clk_q, sr_clk_d;
    logic                   sr_data_q, sr_data_d;
    logic                   mismatch_q, mismatch_d;
    logic                   pass_end;

    // Next-state and next-output computation for the load sequencer
    always_comb begin
        state_d    = state_q;
        div_cnt_d  = div_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        word_d     = word_q;
        tx_d       = tx_q;
        cap_d      = cap_q;
        rd_word_d  = rd_word_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        sr_clk_d   = sr_clk_q;
        sr_data_d  = sr_data_q;
        mismatch_d = mismatch_q;
        pass_end   = 1'b0;

        case (state_q)
            S_IDLE: begin
                sr_clk_d  = 1'b0;
                sr_data_d = 1'b0;
                if (start) begin
                    word_d    = cfg_word;
                    tx_d      = cfg_word;
                    sr_data_d = cfg_word[CHAIN_LEN-1];
                    bit_cnt_d = '0;
                    div_cnt_d = '0;
                    busy_d    = 1'b1;
                    state_d   = S_SHIFT;
                end
            end
`ifdef READBACK_VERIFY_EN
            S_SHIFT, S_VERIFY: begin
`else
            S_SHIFT: begin
`endif
                if (div_cnt_q != DIV_LAST) begin
                    div_cnt_d = div_cnt_q + DW'(1);
                end else begin
                    div_cnt_d = '0;
                    if (!sr_clk_q) begin
                        // rising edge of sr_clk: the chain shifts, capture its output
                        sr_clk_d = 1'b1;
                        cap_d    = {cap_q[CHAIN_LEN-2:0], sr_dout};
                    end else if (bit_cnt_q != BIT_LAST) begin
                        // falling edge: present the next bit
                        sr_clk_d  = 1'b0;
                        bit_cnt_d = bit_cnt_q + BW'(1);
                        tx_d      = tx_q << 1;
                        sr_data_d = tx_q[CHAIN_LEN-2];
                    end else begin
                        sr_clk_d  = 1'b0;
                        bit_cnt_d = '0;
                        pass_end  = 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (pass_end) begin
`ifdef READBACK_VERIFY_EN
            if (state_q == S_SHIFT) begin
                // second pass starts immediately with the same word
                state_d   = S_VERIFY;
                tx_d      = word_q;
                sr_data_d = word_q[CHAIN_LEN-1];
            end else begin
                state_d    = S_DONE;
                busy_d     = 1'b0;
                done_d     = 1'b1;
                sr_data_d  = 1'b0;
                rd_word_d  = cap_q;
                mismatch_d = (cap_q != word_q);
            end
`else
            state_d    = S_DONE;
            busy_d     = 1'b0;
            done_d     = 1'b1;
            sr_data_d  = 1'b0;
            rd_word_d  = cap_q;
`endif
        end
    end

    // State and registered outputs, cleared asynchronously by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            div_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            word_q     <= '0;
            tx_q       <= '0;
            cap_q      <= '0;
            rd_word_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            sr_clk_q   <= 1'b0;
            sr_data_q  <= 1'b0;
            mismatch_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_cnt_q  <= div_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            word_q     <= word_d;
            tx_q       <= tx_d;
            cap_q      <= cap_d;
            rd_word_q  <= rd_word_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            sr_clk_q   <= sr_clk_d;
            sr_data_q  <= sr_data_d;
            mismatch_q <= mismatch_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign rd_word = rd_word_q;
    assign sr_clk  = sr_clk_q;
    assign sr_data = sr_data_q;
`ifdef READBACK_VERIFY_EN
    assign mismatch = mismatch_q;
`else
    // single-pass build has no compare output
    logic unused_mismatch;
    assign unused_mismatch = mismatch_q;
`endif

endmodule

// File: tb/tb_scan_chain_loader.sv
// Directed bench for scan_chain_loader: two instances (CLK_DIV=4 and 1),
// each driving a behavioural 34-stage chain model.
module tb_scan_chain_loader;

`ifdef READBACK_VERIFY_EN
    localparam int PASSES = 2;
`else
    localparam int PASSES = 1;
`endif
    localparam logic [33:0] STUCK_MASK = 34'h1_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  start, busy, done, sr_clk, sr_data, sr_dout;
    logic [33:0] cfg0, cfg1, rd0, rd1;
    logic [33:0] chain0, chain1;
    logic        clr0, clr1, stuck0;
`ifdef READBACK_VERIFY_EN
    logic        mismatch0, mismatch1;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    scan_chain_loader #(.CHAIN_LEN(34), .CLK_DIV(4)) dut0 (
        .clk(clk), .reset(reset), .start(start[0]), .cfg_word(cfg0),
        .busy(busy[0]), .done(done[0]), .rd_word(rd0),
        .sr_clk(sr_clk[0]), .sr_data(sr_data[0]), .sr_dout(sr_dout[0])
`ifdef READBACK_VERIFY_EN
        , .mismatch(mismatch0)
`endif
    );

    scan_chain_loader #(.CHAIN_LEN(34), .CLK_DIV(1)) dut1 (
        .clk(clk), .reset(reset), .start(start[1]), .cfg_word(cfg1),
        .busy(busy[1]), .done(done[1]), .rd_word(rd1),
        .sr_clk(sr_clk[1]), .sr_data(sr_data[1]), .sr_dout(sr_dout[1])
`ifdef READBACK_VERIFY_EN
        , .mismatch(mismatch1)
`endif
    );

    // chain model for dut0, with optional stage-33 stuck-at-0
    always @(posedge sr_clk[0] or posedge clr0) begin
        if (clr0) chain0 <= '0;
        else      chain0 <= {chain0[32:0], sr_data[0]} & (stuck0 ? STUCK_MASK : {34{1'b1}});
    end

    // chain model for dut1
    always @(posedge sr_clk[1] or posedge clr1) begin
        if (clr1) chain1 <= '0;
        else      chain1 <= {chain1[32:0], sr_data[1]};
    end

    assign sr_dout = {chain1[33], chain0[33]};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    endtask

    task automatic clear_chains();
        clr0 = 1'b1; clr1 = 1'b1;
        #1;
        clr0 = 1'b0; clr1 = 1'b0;
    endtask

    // Run one load on instance sel; returns cycles from busy rise to done (-1 if none/aborted)
    task automatic run_load(input int sel, input logic [33:0] cfg, input int inject_at,
                            input logic [33:0] inject_cfg, input int abort_at,
                            output int cycles, output logic busy_at_done,
                            output int tog_err, output logic aborted);
        logic prev_clk;
        cycles = -1; busy_at_done = 1'b1; tog_err = 0; aborted = 1'b0; prev_clk = 1'b0;
        @(negedge clk);
        if (sel == 0) begin cfg0 = cfg; start[0] = 1'b1; end
        else          begin cfg1 = cfg; start[1] = 1'b1; end
        @(negedge clk);
        start = 2'b00;
        for (int n = 1; n <= 2000; n++) begin
            @(negedge clk);
            if (n == abort_at) begin
                reset = 1'b1;
                #1;
                aborted = 1'b1;
                check("abort_sr_clk", {63'd0, sr_clk[sel]}, 64'd0);
                check("abort_busy", {63'd0, busy[sel]}, 64'd0);
                check("abort_done", {63'd0, done[sel]}, 64'd0);
                @(negedge clk);
                reset = 1'b0;
                break;
            end
            if (done[sel]) begin
                cycles = n;
                busy_at_done = busy[sel];
                break;
            end
            if (sel == 1 && busy[1]) begin
                if (sr_clk[1] == prev_clk) tog_err++;
                prev_clk = sr_clk[1];
            end
            if (n == inject_at) begin
                start[sel] = 1'b1;
                if (sel == 0) cfg0 = inject_cfg; else cfg1 = inject_cfg;
            end else begin
                start[sel] = 1'b0;
            end
        end
        start = 2'b00;
        $display("load dut%0d cfg=%h cycles=%0d aborted=%0d", sel, cfg, cycles, aborted);
    endtask

    initial begin
        int          cyc, terr;
        logic        bad, ab;
        logic [33:0] exp_rd;

        reset = 1'b1; start = 2'b00; cfg0 = '0; cfg1 = '0;
        clr0 = 1'b0; clr1 = 1'b0; stuck0 = 1'b0;
        clear_chains();
        repeat (3) @(negedge clk);
        check("rst_busy", {63'd0, busy[0]}, 64'd0);
        check("rst_done", {63'd0, done[0]}, 64'd0);
        check("rst_sr_clk", {63'd0, sr_clk[0]}, 64'd0);
        check("rst_sr_data", {63'd0, sr_data[0]}, 64'd0);
        check("rst_rd_word", {30'd0, rd0}, 64'd0);
`ifdef READBACK_VERIFY_EN
        check("rst_mismatch", {63'd0, mismatch0}, 64'd0);
`endif
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // basic load into a zeroed chain
        run_load(0, 34'h2_AAAA_5555, -1, '0, -1, cyc, bad, terr, ab);
        check("basic_cycles", 64'(cyc), 64'(272 * PASSES));
        check("basic_busy_at_done", {63'd0, bad}, 64'd0);
`ifdef READBACK_VERIFY_EN
        exp_rd = 34'h2_AAAA_5555;
        check("basic_mismatch", {63'd0, mismatch0}, 64'd0);
`else
        exp_rd = 34'h0;
`endif
        check("basic_rd_word", {30'd0, rd0}, {30'd0, exp_rd});
        check("basic_chain", {30'd0, chain0}, {30'd0, 34'h2_AAAA_5555});
        repeat (5) @(negedge clk);
        check("basic_rd_hold", {30'd0, rd0}, {30'd0, exp_rd});
        check("idle_sr_data", {63'd0, sr_data[0]}, 64'd0);

        // back-to-back loads
        run_load(0, 34'h3_FFFF_FFFF, -1, '0, -1, cyc, bad, terr, ab);
        run_load(0, 34'h0_0000_0001, -1, '0, -1, cyc, bad, terr, ab);
`ifdef READBACK_VERIFY_EN
        exp_rd = 34'h0_0000_0001;
`else
        exp_rd = 34'h3_FFFF_FFFF;
`endif
        check("b2b_rd_word", {30'd0, rd0}, {30'd0, exp_rd});
        check("b2b_chain", {30'd0, chain0}, {30'd0, 34'h0_0000_0001});

        // start while busy is ignored
        run_load(0, 34'h1_0F0F_F0F0, 100, 34'h2_0000_0000, -1, cyc, bad, terr, ab);
        check("busy_start_cycles", 64'(cyc), 64'(272 * PASSES));
        check("busy_start_chain", {30'd0, chain0}, {30'd0, 34'h1_0F0F_F0F0});
        repeat (3) @(negedge clk);
        check("busy_start_idle", {63'd0, busy[0]}, 64'd0);

        // reset mid-load, then a full reload
        run_load(0, 34'h3_1234_5678, -1, '0, 150, cyc, bad, terr, ab);
        check("abort_seen", {63'd0, ab}, 64'd1);
        check("abort_rd_word", {30'd0, rd0}, 64'd0);
        run_load(0, 34'h0_DEAD_BEEF, -1, '0, -1, cyc, bad, terr, ab);
        check("reload_cycles", 64'(cyc), 64'(272 * PASSES));
        check("reload_chain", {30'd0, chain0}, {30'd0, 34'h0_DEAD_BEEF});
`ifdef READBACK_VERIFY_EN
        check("reload_rd_word", {30'd0, rd0}, {30'd0, 34'h0_DEAD_BEEF});
        check("reload_mismatch", {63'd0, mismatch0}, 64'd0);

        // stage 33 stuck at 0 with cfg[33]=1 must flag a mismatch
        clear_chains();
        stuck0 = 1'b1;
        run_load(0, 34'h2_0000_00FF, -1, '0, -1, cyc, bad, terr, ab);
        check("stuck_mismatch", {63'd0, mismatch0}, 64'd1);
        check("stuck_rd_bit33", {63'd0, rd0[33]}, 64'd0);
        check("stuck_rd_word", {30'd0, rd0}, {30'd0, 34'h0_0000_00FF});
        stuck0 = 1'b0;
`endif

        // CLK_DIV=1 instance
        clear_chains();
        run_load(1, 34'h1_2345_6789, -1, '0, -1, cyc, bad, terr, ab);
        check("div1_cycles", 64'(cyc), 64'(68 * PASSES));
        check("div1_toggle_errors", 64'(terr), 64'd0);
        check("div1_chain", {30'd0, chain1}, {30'd0, 34'h1_2345_6789});
        check("div1_rd_word", {30'd0, rd1},
              {30'd0, (PASSES == 2) ? 34'h1_2345_6789 : 34'h0});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/scan_chain_loader.md
SCAN_CHAIN_LOADER -- requirements
Module: scan_chain_loader

Interface
REQ-001 The block SHALL provide parameter CHAIN_LEN, default 34, which is the number of serial stages in the on-chip control-register chain, including the trailing dummy stage.
REQ-002 The block SHALL provide parameter CLK_DIV, default 4, which is the half-period of sr_clk in clk cycles; the legal minimum is 1.
REQ-003 The block SHALL provide port clk, input, 1 bit, the system clock; all logic uses its rising edge.
REQ-004 The block SHALL provide port reset, input, 1 bit, asynchronous and active-high.
REQ-005 The block SHALL provide port start, input, 1 bit, a single-cycle load request.
REQ-006 The block SHALL provide port cfg_word, input, CHAIN_LEN bits, the word to be loaded; bit k lands in chain stage k counted from the chain input.
  - CHAIN_LEN=34 map: [15-n]=DSR_n; [16..18]=SR_LATCH_MUX_SEL_2..0; [19]=SA_RFBS_LF_EN; [20]=CML_RFBS_LF_EN.
  - [21..24]=LF_CML I PAD_ED, I OFF_ON, Q PAD_ED, Q OFF_ON; [25..28]=LF_SA same order.
  - [29]=LF_SA_S1_TAIL_VBIAS_EN; [30]=LF_CML_S1_TAIL_VBIAS_EN; [31]=LF_ED_OFF_ON; [32]=SAMPLE_CLOCK_POLARITY; [33]=dummy.
REQ-007 The block SHALL provide port busy, output, 1 bit, high while a load is in progress.
REQ-008 The block SHALL provide port done, output, 1 bit, a one-cycle pulse at load completion.
REQ-009 The block SHALL provide port rd_word, output, CHAIN_LEN bits, the chain contents shifted out during the load, in the same layout as cfg_word.
REQ-010 The block SHALL provide port sr_clk, output, 1 bit, the chain shift clock.
REQ-011 The block SHALL provide port sr_data, output, 1 bit, serial data driven into the chain input.
REQ-012 The block SHALL provide port sr_dout, input, 1 bit, serial data returned from the chain's dummy stage.
REQ-013 The block SHALL provide port mismatch, output, 1 bit, the readback compare failure flag; it is present only when the macro in REQ-025 is defined.

Function
REQ-014 The block SHALL implement states IDLE, SHIFT, VERIFY (macro builds only) and DONE.
REQ-015 In IDLE, start=1 SHALL latch cfg_word, clear the bit counter, and move to SHIFT, with busy=1 from the next cycle.
REQ-016 start SHALL be ignored whenever busy=1 or done=1.
REQ-017 Each bit SHALL occupy 2*CLK_DIV clk cycles: sr_clk low for CLK_DIV cycles, then high for CLK_DIV cycles.
REQ-018 sr_data SHALL change only on the clk cycle at which sr_clk falls or at which a pass begins, and SHALL be stable for the whole high phase.
REQ-019 Bits SHALL be shifted MSB first, from cfg_word[CHAIN_LEN-1] down to cfg_word[0].
REQ-020 sr_dout SHALL be sampled on the clk edge at which sr_clk rises; the sample from rise i (i=0 first) SHALL be stored in rd_word[CHAIN_LEN-1-i].
REQ-021 After CHAIN_LEN rising edges of sr_clk the block SHALL return sr_clk low and leave SHIFT; one pass therefore takes exactly CHAIN_LEN*2*CLK_DIV cycles.
REQ-022 DONE SHALL last one cycle with done=1 and busy=0, then return to IDLE.
REQ-023 rd_word SHALL update only at DONE and SHALL hold its value until the next DONE.
REQ-024 Outside SHIFT and VERIFY, sr_clk SHALL be 0 and sr_data SHALL be 0.

Configuration
REQ-025 With READBACK_VERIFY_EN defined, SHIFT SHALL be followed by VERIFY, a second identical pass of the latched word.
  - rd_word takes the VERIFY-pass samples.
  - mismatch is set at DONE to (rd_word != latched cfg) and holds until the next DONE.
  - Total load time is 2*CHAIN_LEN*2*CLK_DIV cycles.
REQ-026 Without READBACK_VERIFY_EN, the block SHALL perform a single pass, and neither the mismatch port nor the VERIFY state SHALL exist.

Reset
REQ-027 While reset=1, the block SHALL force state=IDLE, busy=0, done=0, sr_clk=0, sr_data=0, rd_word=0, mismatch=0 and the counters to 0, asynchronously.
REQ-028 Assertion of reset during SHIFT or VERIFY SHALL abort the load immediately with no done pulse; chain contents are then undefined, and the next start performs a full reload.

Verification
REQ-029 Bench scenario, basic load: CHAIN_LEN=34, CLK_DIV=4, a chain model initialised to 0, start with cfg=34'h2_AAAA_5555. Required response:
  - done exactly 272 cycles after busy rises.
  - chain model equals 34'h2_AAAA_5555.
  - rd_word=0.
REQ-030 Bench scenario, back-to-back loads: load 34'h3_FFFF_FFFF, then load 34'h0_0000_0001. Required response: the second load gives rd_word=34'h3_FFFF_FFFF and chain=34'h0_0000_0001.
REQ-031 Bench scenario, start while busy: pulse start at cycle 100 of a load, with a different cfg. Required response: it is ignored, and the pass length and chain contents are unchanged.
REQ-032 Bench scenario, reset mid-load: assert reset at cycle 150. Required response: sr_clk=0, busy=0, no done; a following full load completes correctly.
REQ-033 Bench scenario, READBACK_VERIFY_EN with a correct chain model: required response is done at 544 cycles and mismatch=0.
  - Variant: chain model with stage 33 stuck-at-0 and cfg[33]=1. Required response: mismatch=1 and rd_word[33]=0.
REQ-034 Bench scenario, CLK_DIV=1: load 34'h1_2345_6789. Required response: done at 68 cycles, sr_clk toggles every cycle, and the chain is correct.
